// File: rtl/ifetch_pc_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch front end:
// widths, reset/bubble constants, the IF/ID bundle and the fetch-state enum.
package ifetch_pc_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_FETCH    = 1'b0,
        ST_REDIRECT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } ifid_t;

    // A bubble carries the NOP encoding, a zero PC and no valid bit.
    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop_word);
        ifid_t b;
        b.instr = nop_word;
        b.pc    = {XLEN{1'b0}};
        b.valid = 1'b0;
        return b;
    endfunction

    // Word-align a branch target.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
        return {t[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction bus and
// loads IF/ID; a branch behind an in-flight fetch waits in redirect_pc_r.
module ifetch_pc_unit #(
    parameter int              XLEN      = ifetch_pc_unit_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = ifetch_pc_unit_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = ifetch_pc_unit_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_IF,
    input  logic            nop_IF,
    input  logic            branch_PC_contral,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] iaddr,
    output logic            ireq,
    input  logic [XLEN-1:0] idata,
    input  logic            iready_n,
    output logic [XLEN-1:0] instr_ID,
    output logic [XLEN-1:0] pc_ID,
    output logic            valid_ID
);
    import ifetch_pc_unit_pkg::*;

    // The IF/ID bundle is sized by the shared package; XLEN must track it.
    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [XLEN-1:0] redirect_pc_r;
    logic [XLEN-1:0] redirect_nxt_s;
    ifid_t           ifid_r;
    ifid_t           ifid_nxt_s;
    logic            ireq_r;
    logic [XLEN-1:0] target_s;
    logic            accept_s;

    assign target_s = align_target(branch_target);
    assign accept_s = ~iready_n;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: only a branch that cannot retire immediately parks us in REDIRECT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (branch_PC_contral && iready_n) begin
                    state_nxt_s = ST_REDIRECT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_REDIRECT: begin
                if (accept_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_REDIRECT;
                end
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // Datapath next values: PC, pending redirect target and IF/ID contents.
    always_comb begin
        pc_nxt_s       = pc_r;
        redirect_nxt_s = redirect_pc_r;
        ifid_nxt_s     = ifid_r;
        case (state_r)
            ST_FETCH: begin
                if (branch_PC_contral) begin
                    ifid_nxt_s = ifid_bubble(NOP_INSTR);
                    if (accept_s) begin
                        pc_nxt_s = target_s;
                    end else begin
                        redirect_nxt_s = target_s;
                    end
                end else if (stall_IF) begin
                    pc_nxt_s   = pc_r;
                    ifid_nxt_s = ifid_r;
                end else if (nop_IF) begin
                    ifid_nxt_s = ifid_bubble(NOP_INSTR);
                end else if (accept_s) begin
                    ifid_nxt_s.instr = idata;
                    ifid_nxt_s.pc    = pc_r;
                    ifid_nxt_s.valid = 1'b1;
                    pc_nxt_s         = pc_r + 32'd4;
                end else begin
                    pc_nxt_s   = pc_r;
                    ifid_nxt_s = ifid_r;
                end
            end
            ST_REDIRECT: begin
                // Data returning for the stale fetch is dropped; stall/nop do not delay the exit.
                ifid_nxt_s = ifid_bubble(NOP_INSTR);
                if (accept_s) begin
                    if (branch_PC_contral) begin
                        pc_nxt_s = target_s;
                    end else begin
                        pc_nxt_s = redirect_pc_r;
                    end
                end else if (branch_PC_contral) begin
                    redirect_nxt_s = target_s;
                end else begin
                    redirect_nxt_s = redirect_pc_r;
                end
            end
            default: begin
                ifid_nxt_s = ifid_bubble(NOP_INSTR);
            end
        endcase
    end

    // Datapath registers, including the bus request which drops while reset is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            redirect_pc_r <= {XLEN{1'b0}};
            ifid_r        <= ifid_bubble(NOP_INSTR);
            ireq_r        <= 1'b0;
        end else begin
            pc_r          <= pc_nxt_s;
            redirect_pc_r <= redirect_nxt_s;
            ifid_r        <= ifid_nxt_s;
            ireq_r        <= 1'b1;
        end
    end

    assign iaddr    = pc_r;
    assign ireq     = ireq_r;
    assign instr_ID = ifid_r.instr;
    assign pc_ID    = ifid_r.pc;
    assign valid_ID = ifid_r.valid;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Self-checking bench for ifetch_pc_unit: directed test-plan sequence followed
// by random stimulus, all compared against a behavioural fetch model.
module tb_ifetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_IF = 1'b0;
    logic        nop_IF = 1'b0;
    logic        branch_PC_contral = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] iaddr;
    logic        ireq;
    logic [31:0] idata = 32'd0;
    logic        iready_n = 1'b1;
    logic [31:0] instr_ID;
    logic [31:0] pc_ID;
    logic        valid_ID;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural PC, pending redirect and the ID slot.
    logic [31:0] m_pc = 32'd0;
    logic        m_pending = 1'b0;
    logic [31:0] m_pending_pc = 32'd0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pcid = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_ireq = 1'b0;

    ifetch_pc_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stall_IF          (stall_IF),
        .nop_IF            (nop_IF),
        .branch_PC_contral (branch_PC_contral),
        .branch_target     (branch_target),
        .iaddr             (iaddr),
        .ireq              (ireq),
        .idata             (idata),
        .iready_n          (iready_n),
        .instr_ID          (instr_ID),
        .pc_ID             (pc_ID),
        .valid_ID          (valid_ID)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic bubble_model();
        m_instr = NOP;
        m_pcid  = 32'd0;
        m_valid = 1'b0;
    endtask

    // One clock edge of the fetch rules, written directly from the behaviour description.
    task automatic model_step();
        logic [31:0] tgt;
        logic        got_data;
        tgt      = branch_target & 32'hFFFF_FFFC;
        got_data = !iready_n;
        if (rst) begin
            m_pc = 32'd0; m_pending = 1'b0; m_pending_pc = 32'd0; m_ireq = 1'b0;
            bubble_model();
        end else begin
            m_ireq = 1'b1;
            if (m_pending) begin
                bubble_model();
                if (got_data) begin
                    m_pc      = branch_PC_contral ? tgt : m_pending_pc;
                    m_pending = 1'b0;
                end else if (branch_PC_contral) begin
                    m_pending_pc = tgt;
                end
            end else if (branch_PC_contral) begin
                bubble_model();
                if (got_data) begin
                    m_pc = tgt;
                end else begin
                    m_pending    = 1'b1;
                    m_pending_pc = tgt;
                end
            end else if (stall_IF) begin
                m_pc = m_pc;
            end else if (nop_IF) begin
                bubble_model();
            end else if (got_data) begin
                m_instr = idata;
                m_pcid  = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic st, input logic np, input logic br,
                         input logic [31:0] tgt, input logic rn, input logic [31:0] d);
        rst = r; stall_IF = st; nop_IF = np; branch_PC_contral = br;
        branch_target = tgt; iready_n = rn; idata = d;
        @(posedge clk);
        model_step();
        #1;
        check_val("iaddr", iaddr, m_pc);
        check_val("ireq", {31'd0, ireq}, {31'd0, m_ireq});
        check_val("instr_ID", instr_ID, m_instr);
        check_val("pc_ID", pc_ID, m_pcid);
        check_val("valid_ID", {31'd0, valid_ID}, {31'd0, m_valid});
    endtask

    initial begin
        // Reset, then in-order fetch of A0/A1.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        check_val("rst_iaddr", iaddr, 32'd0);
        check_val("rst_instr", instr_ID, NOP);
        check_val("rst_ireq", {31'd0, ireq}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        check_val("ireq_up", {31'd0, ireq}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hA0);
        check_val("a0_instr", instr_ID, 32'hA0);
        check_val("a0_iaddr", iaddr, 32'h4);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hA1);
        check_val("a1_pc", pc_ID, 32'h4);
        // Stall three cycles with data ready: everything held.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'hEE);
            check_val("stall_instr", instr_ID, 32'hA1);
            check_val("stall_iaddr", iaddr, 32'h8);
        end
        // One nop: bubble in ID and address 8 replayed.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'hEE);
        check_val("nop_valid", {31'd0, valid_ID}, 32'd0);
        check_val("nop_iaddr", iaddr, 32'h8);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hA2);
        check_val("a2_pc", pc_ID, 32'h8);
        // Branch with the bus ready.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'hEE);
        check_val("br_iaddr", iaddr, 32'h100);
        check_val("br_bubble", {31'd0, valid_ID}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hB0);
        check_val("br_first", pc_ID, 32'h100);
        // Branch behind an in-flight fetch.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'd0);
        check_val("rd_hold", iaddr, 32'h104);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'hDEAD);
        check_val("rd_drop", {31'd0, valid_ID}, 32'd0);
        check_val("rd_exit", iaddr, 32'h200);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hC0);
        // Second branch during the wait wins.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hBEEF);
        check_val("rd_newest", iaddr, 32'h300);
        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hD0);
        check_val("wrap_iaddr", iaddr, 32'd0);
        check_val("wrap_pcid", pc_ID, 32'hFFFF_FFFC);
        // Reset while a redirect is pending.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        check_val("rstrd_iaddr", iaddr, 32'd0);
        check_val("rstrd_valid", {31'd0, valid_ID}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hF0);
        check_val("rstrd_no_old", iaddr, 32'h4);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0),
                  tgt,
                  ($urandom_range(0, 1) == 1),
                  $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_pc_unit.md
# ifetch_pc_unit

Instruction-fetch front end of the 5-stage pipeline. Owns the program counter and drives the instruction-bus request. Loads the IF/ID pipeline register under the stall/nop controls from the hazard unit, and redirects on a taken branch. A branch that arrives while a fetch is still in flight is held and applied once the bus returns. The data from that in-flight fetch is discarded.

## Interface
Parameters:
- `XLEN`, 32, address/instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, bubble encoding written into IF/ID

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall_IF`  in  1  hold PC and IF/ID contents
- `nop_IF`  in  1  write a bubble into IF/ID; do not advance PC (replay)
- `branch_PC_contral`  in  1  taken branch/jump this cycle
- `branch_target`  in  XLEN  redirect address; bits [1:0] forced to 0
- `iaddr`  out  XLEN  instruction bus address (registered)
- `ireq`  out  1  fetch request
- `idata`  in  XLEN  instruction bus read data
- `iready_n`  in  1  active-low: `idata` valid for `iaddr` this cycle
- `instr_ID`  out  XLEN  IF/ID instruction
- `pc_ID`  out  XLEN  IF/ID PC
- `valid_ID`  out  1  IF/ID holds a real instruction

## Operation
- State machine with two states:
  - FETCH: normal operation.
  - REDIRECT: a branch target is pending behind an in-flight fetch.
- `iaddr` = `pc` register. `ireq` = 1 in both states; `ireq` = 0 while `rst`.
- FETCH, per cycle, highest priority first:
  1. `branch_PC_contral` with `iready_n`=0: `pc`<=target; IF/ID<=bubble; stay FETCH.
  2. `branch_PC_contral` with `iready_n`=1: `redirect_pc`<=target; `pc` held; IF/ID<=bubble; go to REDIRECT.
  3. `stall_IF`: `pc` and IF/ID held. `valid_ID` is unchanged.
  4. `nop_IF`: `pc` held, so the same address is refetched; IF/ID<=bubble.
  5. `iready_n`=0: IF/ID<={`idata`, `pc`, 1}; `pc`<=`pc`+4.
  6. Otherwise: `pc` and IF/ID held.
- REDIRECT:
  - IF/ID<=bubble every cycle.
  - A new `branch_PC_contral` overwrites `redirect_pc`; the newest target wins.
  - On `iready_n`=0: `idata` is discarded, `pc`<=`redirect_pc`, go to FETCH. This exit ignores `stall_IF` and `nop_IF`.
  - If a branch and `iready_n`=0 arrive in the same cycle, the new target goes straight to `pc`.
- Bubble means `instr_ID`=NOP_INSTR, `pc_ID`=0, `valid_ID`=0.
- `pc`+4 wraps modulo 2^XLEN. A target's low 2 bits are masked before use.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `pc`/`iaddr`=RESET_PC, `redirect_pc`=0, state=FETCH.
  - `instr_ID`=NOP_INSTR, `pc_ID`=0, `valid_ID`=0.
- Reset mid-REDIRECT abandons the pending target. Any in-flight return is ignored because state is FETCH with `iaddr`=RESET_PC.
- Fetch-to-ID latency: 1 cycle. An instruction accepted at edge N appears on `*_ID` after edge N.
- Branch at edge N:
  - With `iready_n`=0: `iaddr`=target after N, and the first target instruction is in ID after N+1.
  - With `iready_n`=1: the target is issued one cycle after the in-flight fetch completes.
- `iaddr` is stable while `iready_n`=1; it changes only on acceptance, redirect, or reset.
- No combinational path from inputs to any output.

## Structure
- Shared pipeline package holds:
  - `XLEN`
  - `NOP_INSTR`
  - `RESET_PC`
  - the IF/ID bundle struct (instr, pc, valid)
  - the two-value fetch-state enum
- No sub-module; a single flat block containing the PC register, the redirect register, and the IF/ID register.

## Test plan
- Reset, then `iready_n`=0 each cycle with `idata`=0xA0,0xA1,0xA2:
  - `iaddr` = 0, 4, 8.
  - `instr_ID`/`pc_ID` = 0xA0/0, 0xA1/4, 0xA2/8 one cycle later.
  - `valid_ID`=1.
- `nop_IF` for 1 cycle at `pc`=8:
  - `valid_ID`=0 for that cycle.
  - `iaddr` stays 8, and 8 is refetched and delivered next.
- `stall_IF` for 3 cycles with `instr_ID`=0xA1:
  - `iaddr` and `instr_ID`/`pc_ID`/`valid_ID` are held for 3 cycles.
  - Fetch resumes at the same `pc`.
- Branch to 0x103 with `iready_n`=0:
  - `iaddr`=0x100 next cycle.
  - Bubble in ID for one cycle, then the instruction from 0x100.
- Branch to 0x200 while `iready_n`=1 for 2 more cycles:
  - `iaddr` is held at the old `pc`, and the returned data is discarded (`valid_ID`=0).
  - `iaddr`=0x200 the cycle after the return.
  - If a second branch to 0x300 arrives during the wait, `iaddr`=0x300 instead.
- `pc`=0xFFFF_FFFC, accept one instruction: `iaddr` wraps to 0. Separately, assert `rst` during REDIRECT: `iaddr`=RESET_PC and `valid_ID`=0.
